cnn_classifier: RTL and testbench
=================================

// Module: cnn_classifier
// PURPOSE
//   Tiny fixed-weight CNN classifier for 16x16 binary blood-cell images (malaria screen).
//   Pipeline: 3x3 all-ones convolution -> 14x14 feature map -> zero-pad to 16x16 -> 2x2 max-pool
//   -> 8x8 map -> sum-threshold classifier -> 1-bit result (1 = parasitized, 0 = clean).
//   Multi-cycle, FSM-sequenced block sitting after image binarization; one image in flight.
// PARAMETERS
//   SUM_THRESH  256  result=1 when sum of all 64 pooled values >= SUM_THRESH (10-bit compare)
// PORTS
//   clk           in   1    single clock, rising edge
//   rst_n         in   1    asynchronous active-low reset
//   start         in   1    request; sampled only in IDLE
//   binary_image  in   256  pixel(r,c) = binary_image[r*16+c], r,c in 0..15
//   busy          out  1    high from the cycle after start is accepted until done
//   done          out  1    one-cycle pulse when result is updated
//   result        out  1    classification, held until next done
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; image latch, featuremap,
//     padded, pooled, counters and sum all cleared. Reset mid-operation aborts; no done pulse.
//   Internal regs (hierarchically probed by bench, 4-bit cells, LSB-first packing):
//     featuremap[783:0] cell(i,j)=[(i*14+j)*4+:4]; padded[1023:0] cell(i,j)=[(i*16+j)*4+:4];
//     pooled[255:0] cell(i,j)=[(i*8+j)*4+:4].
//   FSM: IDLE -> CONV -> PAD -> POOL -> CLASS -> IDLE.
//     IDLE: start=1 at an edge -> latch binary_image, go CONV, busy=1 next cycle.
//     CONV: 196 cycles, one cell/cycle in raster order (i,j 0..13):
//       featuremap(i,j) = count of ones in pixel(i..i+2, j..j+2); range 0..9, fits 4 bits.
//     PAD: 1 cycle: padded(i,j)=featuremap(i-1,j-1) for i,j in 1..14, else 0.
//     POOL: 64 cycles, one cell/cycle raster: pooled(i,j)=max of padded(2i..2i+1, 2j..2j+1);
//       running 10-bit sum of pooled cells accumulated (max 576, no overflow).
//     CLASS: 1 cycle: result <= (sum >= SUM_THRESH); done=1 this cycle; busy=0; -> IDLE.
//   Latency: done asserted in the 262nd cycle after the start-sampling edge
//     (196 CONV + 1 PAD + 64 POOL + 1 CLASS); next start accepted the cycle after done.
//   start while busy: ignored (no queue). start held high: a new run begins the cycle after done.
//   binary_image changes after start acceptance do not affect the run in progress.
//   Internal maps keep final values until the next accepted start.
// CONFIGURATION
//   CNN_DEBUG_EN defined: extra output port dbg_pooled [255:0] = pooled register, continuously
//     driven, plus dbg_sum [9:0] = current accumulated sum.
//   Not defined: ports absent; pooled/sum remain internal only; core behaviour identical.
// TESTING
//   All-zero image, start -> done after 262 cycles, every map cell 0, result=0.
//   All-ones image -> featuremap all 9; padded border 0, interior 9; pooled all 9; sum 576; result=1.
//   Single pixel (8,8)=1 -> featuremap 1 at (6..8,6..8), others 0; sum<=4; result=0.
//   Filled disc radius ~6 centred (8,8) -> sum >= 256 -> result=1; then
//     all-zero image -> result returns 0.
//   Assert rst_n=0 mid-POOL -> busy/done/result=0 immediately; no done; fresh start completes
//     normally.
//   Pulse start while busy -> ignored, exactly one done per accepted start; done is 1 cycle wide.

Source files
------------

// File: rtl/cnn_classifier.sv
// Fixed-weight 3x3-sum / pad / 2x2 max-pool / sum-threshold classifier for 16x16 binary images.
// Optional macro CNN_DEBUG_EN exposes the pooled map and running sum as debug ports.
module cnn_classifier #(
  parameter int SUM_THRESH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] binary_image,
  output logic         busy,
  output logic         done,
  output logic         result
`ifdef CNN_DEBUG_EN
  ,
  output logic [255:0] dbg_pooled,
  output logic [9:0]   dbg_sum
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_PAD, S_POOL, S_CLASS} state_t;

  state_t        r_state;
  logic [255:0]  r_img;
  logic [783:0]  featuremap;
  logic [1023:0] padded;
  logic [255:0]  pooled;
  logic [7:0]    r_cell;
  logic [3:0]    r_row, r_col;
  logic [9:0]    r_sum;

  logic [7:0] w_base;
  logic [3:0] w_cnt;
  logic [9:0] w_pbase;
  logic [3:0] w_a, w_b, w_c, w_d, w_m0, w_m1, w_max;
  logic [9:0] w_nsum;

  // 3x3 window popcount anchored at (r_row, r_col) of the latched image
  always_comb begin
    w_base = {r_row, 4'b0000} + {4'b0000, r_col};
    w_cnt  = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w_cnt = w_cnt + {3'b000, r_img[w_base + 8'(dr * 16 + dc)]};
  end

  // 2x2 block of the padded map for pooled cell (r_row[2:0], r_col[2:0])
  always_comb begin
    w_pbase = {r_row[2:0], 7'b0} + {4'b0000, r_col[2:0], 3'b000};
    w_a     = padded[w_pbase +: 4];
    w_b     = padded[w_pbase + 10'd4 +: 4];
    w_c     = padded[w_pbase + 10'd64 +: 4];
    w_d     = padded[w_pbase + 10'd68 +: 4];
    w_m0    = (w_a > w_b) ? w_a : w_b;
    w_m1    = (w_c > w_d) ? w_c : w_d;
    w_max   = (w_m0 > w_m1) ? w_m0 : w_m1;
    w_nsum  = r_sum + {6'b0, w_max};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_img      <= '0;
      featuremap <= '0;
      padded     <= '0;
      pooled     <= '0;
      r_cell     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_sum      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Border of padded relies on this clear; PAD only writes the interior
            r_img      <= binary_image;
            featuremap <= '0;
            padded     <= '0;
            pooled     <= '0;
            r_sum      <= '0;
            r_cell     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            busy       <= 1'b1;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          featuremap[{r_cell, 2'b00} +: 4] <= w_cnt;
          if (r_cell == 8'd195) begin
            r_cell  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= S_PAD;
          end else begin
            r_cell <= r_cell + 8'd1;
            if (r_col == 4'd13) begin
              r_col <= '0;
              r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        S_PAD: begin
          for (int i = 0; i < 14; i++)
            for (int j = 0; j < 14; j++)
              padded[((i + 1) * 16 + j + 1) * 4 +: 4] <= featuremap[(i * 14 + j) * 4 +: 4];
          r_state <= S_POOL;
        end
        S_POOL: begin
          pooled[{r_cell[5:0], 2'b00} +: 4] <= w_max;
          r_sum <= w_nsum;
          if (r_cell == 8'd63) begin
            r_cell  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            result  <= (w_nsum >= 10'(SUM_THRESH));
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_CLASS;
          end else begin
            r_cell <= r_cell + 8'd1;
            if (r_col == 4'd7) begin
              r_col <= '0;
              r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        S_CLASS: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CNN_DEBUG_EN
  assign dbg_pooled = pooled;
  assign dbg_sum    = r_sum;
`endif

endmodule

// File: tb/tb_cnn_classifier.sv
// Directed bench for cnn_classifier: array model of conv/pad/pool/threshold plus cycle-timeline checker.
module tb_cnn_classifier;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] image = '0;
  logic         busy, done, result;

  cnn_classifier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary_image(image),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_done = 0;
  int k = 0;
  logic exp_result = 1'b0;
  int m_fm [14][14];
  int m_pad[16][16];
  int m_pool[8][8];
  int m_sum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Straight from the definitions: window counts, shifted copy, block maxima, total
  task automatic model(input logic [255:0] img);
    int c, mx;
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < 14; j++) begin
        c = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            c += int'(img[(i + dr) * 16 + j + dc]);
        m_fm[i][j] = c;
      end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        m_pad[i][j] = (i >= 1 && i <= 14 && j >= 1 && j <= 14) ? m_fm[i-1][j-1] : 0;
    m_sum = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mx = 0;
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++)
            if (m_pad[2*i+a][2*j+b] > mx) mx = m_pad[2*i+a][2*j+b];
        m_pool[i][j] = mx;
        m_sum += mx;
      end
  endtask

  // k = cycle index within a run: 1..261 busy, 262 is the done cycle, 0 idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      exp_result = 1'b0;
    end else if (k == 0) begin
      if (start) begin
        k = 1;
        model(image);
      end
    end else if (k == 261) begin
      k = 262;
      exp_result = (m_sum >= 256);
    end else if (k == 262) begin
      k = 0;
    end else begin
      k++;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(k >= 1 && k <= 261));
    chk("done", 32'(done), 32'(k == 262));
    chk("result", 32'(result), 32'(exp_result));
    if (done === 1'b1) n_done++;
  end

  task automatic check_maps(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < 14; j++)
        if (dut.featuremap[(i*14+j)*4 +: 4] !== 4'(m_fm[i][j])) bad++;
    chk({nm, "_featuremap_bad_cells"}, 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (dut.padded[(i*16+j)*4 +: 4] !== 4'(m_pad[i][j])) bad++;
    chk({nm, "_padded_bad_cells"}, 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (dut.pooled[(i*8+j)*4 +: 4] !== 4'(m_pool[i][j])) bad++;
    chk({nm, "_pooled_bad_cells"}, 32'(bad), 0);
  endtask

  task automatic run(input logic [255:0] img, input string nm, input bit flip, input bit poke);
    int n;
    @(negedge clk);
    image = img;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (flip) image = ~img;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (poke && (n == 50 || n == 120)) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(n), 262);
    check_maps(nm);
    @(negedge clk);
  endtask

  logic [255:0] img_one, img_disc;
  int d0;

  initial begin
    img_one = '0;
    img_one[8*16+8] = 1'b1;
    img_disc = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if ((r-8)*(r-8) + (c-8)*(c-8) <= 40) img_disc[r*16+c] = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_pooled_zero", 32'(dut.pooled != '0), 0);
    #2 rst_n = 1'b1;

    run('0, "zeros", 0, 0);
    chk("zeros_model_sum", 32'(m_sum), 0);
    chk("zeros_result", 32'(result), 0);

    run('1, "ones", 0, 0);
    chk("ones_model_sum", 32'(m_sum), 576);
    chk("ones_result", 32'(result), 1);
    chk("ones_pad_border", 32'(dut.padded[(0*16+5)*4 +: 4]), 0);
    chk("ones_pad_inner", 32'(dut.padded[(5*16+5)*4 +: 4]), 9);
    chk("ones_pool_cell", 32'(dut.pooled[(3*8+4)*4 +: 4]), 9);

    run(img_one, "single", 0, 0);
    chk("single_model_sum", 32'(m_sum), 4);
    chk("single_fm_hit", 32'(dut.featuremap[(7*14+7)*4 +: 4]), 1);
    chk("single_fm_miss", 32'(dut.featuremap[(5*14+5)*4 +: 4]), 0);
    chk("single_result", 32'(result), 0);

    run(img_disc, "disc", 0, 0);
    chk("disc_result", 32'(result), 1);

    run('0, "zeros2", 0, 0);
    chk("zeros2_result", 32'(result), 0);

    // image flipped to all-zero right after acceptance must not disturb the run
    run('1, "flip", 1, 0);
    chk("flip_result", 32'(result), 1);

    // reset during POOL: outputs clear at once, no done follows
    @(negedge clk);
    image = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (229) @(negedge clk);
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_done", 32'(n_done - d0), 0);

    d0 = n_done;
    run(img_disc, "busy_pulse", 0, 1);
    repeat (20) @(negedge clk);
    chk("busy_pulse_one_done", 32'(n_done - d0), 1);
    chk("busy_pulse_result", 32'(result), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
